// File: rtl/serial_frame_rx.sv
// serial_frame_rx: receiver for the single-wire serial frame link.
// Idle-low line, high start bit, DATA_BITS payload bits LSB first, low stop bit.
// Each received byte is offered to the consumer with a valid/ack handshake.
//
// Handshake: `valid` rises on the cycle after a good stop sample and stays high
// until a cycle with ack=1 and valid=1; it then reads 0 on the following cycle.
// If a new frame completes in a cycle where ack=1, the new byte is loaded and
// `valid` stays high. `ack` while valid=0 has no effect.
module serial_frame_rx #(
   parameter int CLKS_PER_BIT = 1,
   parameter int DATA_BITS    = 8,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rxd,
   input  logic                 ack,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy,
   output logic [1:0]           state_test,
   output logic [4:0]           cnt_test
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int TW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] fill_q;
   logic                   rxd_s;
   logic                   prev;
   logic                   edge_seen;

   state_t                 state;
   logic [TW-1:0]          timer;
   logic [4:0]             cnt;
   logic [DATA_BITS-1:0]   shift;

   assign rxd_s     = sync_q[SYNC_STAGES-1];
   assign edge_seen = rxd_s & ~prev;

   // Input synchroniser and previous-sample register for rising-edge detection.
   // fill_q marks when the synchroniser holds only post-reset line samples; until
   // then prev is held at 1 so a line that is already high after reset is not
   // mistaken for a start edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         fill_q <= '0;
         prev   <= 1'b1;
      end else begin
         sync_q <= (sync_q << 1) | SYNC_STAGES'(rxd);
         fill_q <= (fill_q << 1) | SYNC_STAGES'(1'b1);
         prev   <= fill_q[SYNC_STAGES-1] ? rxd_s : 1'b1;
      end
   end

   // Frame FSM: bit timing, payload shift register and the registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         timer     <= '0;
         cnt       <= '0;
         shift     <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         if (ack) valid <= 1'b0;
         case (state)
            IDLE: begin
               timer <= '0;
               // With one clock per bit there is no half-period wait: the edge
               // cycle itself is the start-bit sample.
               if (edge_seen) state <= (HALF == 0) ? DATA : START;
            end
            START: begin
               if (timer == TW'(HALF - 1)) begin
                  timer <= '0;
                  state <= rxd_s ? DATA : IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            DATA: begin
               if (timer == TW'(CLKS_PER_BIT - 1)) begin
                  timer <= '0;
                  shift <= (shift >> 1) | (DATA_BITS'(rxd_s) << (DATA_BITS - 1));
                  if (cnt == 5'(DATA_BITS - 1)) begin
                     cnt   <= '0;
                     state <= STOP;
                  end else begin
                     cnt <= cnt + 5'd1;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            STOP: begin
               if (timer == TW'(CLKS_PER_BIT - 1)) begin
                  timer <= '0;
                  state <= IDLE;
                  if (!rxd_s) begin
                     data    <= shift;
                     valid   <= 1'b1;
                     overrun <= valid & ~ack;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy       = (state != IDLE);
   assign state_test = state;
   assign cnt_test   = cnt;

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: three receivers (4, 1 and 8 clocks per bit) driven by
// frame-level tasks. A transaction scoreboard predicts, for every frame sent,
// the cycle its result appears (start rise + sync + half bit + 9 bit periods + 1)
// and whether it is a byte or a framing error; the monitor compares valid, data,
// frame_err and overrun on every cycle against that prediction.
module tb_serial_frame_rx;

   // ---------------- clock / reset ----------------
   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]      rxd_v, ack_v, rst_v;
   logic [2:0][7:0] data_v;
   logic [2:0]      valid_v, ferr_v, ovr_v, busy_v;
   logic [2:0][1:0] state_v;
   logic [2:0][4:0] cnt_v;

   serial_frame_rx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .SYNC_STAGES(2)) u_rx0 (
      .clk(clk), .rst(rst_v[0]), .rxd(rxd_v[0]), .ack(ack_v[0]),
      .data(data_v[0]), .valid(valid_v[0]), .frame_err(ferr_v[0]), .overrun(ovr_v[0]),
      .busy(busy_v[0]), .state_test(state_v[0]), .cnt_test(cnt_v[0]));

   serial_frame_rx #(.CLKS_PER_BIT(1), .DATA_BITS(8), .SYNC_STAGES(1)) u_rx1 (
      .clk(clk), .rst(rst_v[1]), .rxd(rxd_v[1]), .ack(ack_v[1]),
      .data(data_v[1]), .valid(valid_v[1]), .frame_err(ferr_v[1]), .overrun(ovr_v[1]),
      .busy(busy_v[1]), .state_test(state_v[1]), .cnt_test(cnt_v[1]));

   serial_frame_rx #(.CLKS_PER_BIT(8), .DATA_BITS(8), .SYNC_STAGES(2)) u_rx2 (
      .clk(clk), .rst(rst_v[2]), .rxd(rxd_v[2]), .ack(ack_v[2]),
      .data(data_v[2]), .valid(valid_v[2]), .frame_err(ferr_v[2]), .overrun(ovr_v[2]),
      .busy(busy_v[2]), .state_test(state_v[2]), .cnt_test(cnt_v[2]));

   function automatic int cpb_of(input int s);
      case (s)
         0:       return 4;
         1:       return 1;
         default: return 8;
      endcase
   endfunction

   function automatic int sync_of(input int s);
      return (s == 1) ? 1 : 2;
   endfunction

   // rxd rise cycle -> cycle in which the result is visible
   function automatic int lat_of(input int s);
      return sync_of(s) + cpb_of(s) / 2 + 9 * cpb_of(s) + 1;
   endfunction

   // ---------------- scoreboard ----------------
   // entry: {sel[1:0], good, data[7:0], result_cycle[31:0]}
   logic [42:0] exp_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   logic [2:0]  ack_s = '0;
   logic [2:0]  rst_s = '1;
   bit   [2:0]  m_valid = '0;
   logic [7:0]  m_data[3] = '{8'h00, 8'h00, 8'h00};
   bit          rnd_done;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // inputs as seen by the DUT at each rising edge
   initial begin : sampler
      forever begin
         @(posedge clk);
         ack_s = ack_v;
         rst_s = rst_v;
         cyc   = cyc + 1;
      end
   end

   initial begin : monitor
      logic [42:0] ent;
      int          k;
      bit          e_ferr, e_ovr;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            e_ferr = 1'b0;
            e_ovr  = 1'b0;
            if (rst_s[i]) begin
               m_valid[i] = 1'b0;
               m_data[i]  = 8'h00;
               k = 0;
               while (k < exp_q.size()) begin
                  if (exp_q[k][42:41] == 2'(i)) exp_q.delete(k);
                  else k++;
               end
            end else begin
               k = -1;
               foreach (exp_q[j])
                  if (k < 0 && exp_q[j][42:41] == 2'(i) && exp_q[j][31:0] == 32'(cyc)) k = j;
               if (k >= 0) begin
                  ent = exp_q[k];
                  exp_q.delete(k);
                  if (ent[40]) begin
                     e_ovr      = m_valid[i] & ~ack_s[i];
                     m_valid[i] = 1'b1;
                     m_data[i]  = ent[39:32];
                  end else begin
                     e_ferr     = 1'b1;
                     m_valid[i] = m_valid[i] & ~ack_s[i];
                  end
               end else begin
                  m_valid[i] = m_valid[i] & ~ack_s[i];
               end
            end
            check($sformatf("u%0d.valid", i), 32'(valid_v[i]), 32'(m_valid[i]));
            check($sformatf("u%0d.data", i), 32'(data_v[i]), 32'(m_data[i]));
            check($sformatf("u%0d.frame_err", i), 32'(ferr_v[i]), 32'(e_ferr));
            check($sformatf("u%0d.overrun", i), 32'(ovr_v[i]), 32'(e_ovr));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic send_frame(input int s, input logic [7:0] d, input bit bad_stop);
      int r;
      tick();
      rxd_v[s] = 1'b1;
      r = cyc;
      exp_q.push_back({2'(s), ~bad_stop, d, 32'(r + lat_of(s))});
      repeat (cpb_of(s) - 1) tick();
      for (int b = 0; b < 8; b++) begin
         tick();
         rxd_v[s] = d[b];
         repeat (cpb_of(s) - 1) tick();
      end
      tick();
      rxd_v[s] = bad_stop;
      repeat (cpb_of(s) - 1) tick();
   endtask

   task automatic idle(input int s, input int n);
      repeat (n) begin
         tick();
         rxd_v[s] = 1'b0;
      end
   endtask

   task automatic ack_pulse(input int s);
      tick();
      ack_v[s] = 1'b1;
      tick();
      ack_v[s] = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin : main
      int r;
      int guard;
      rxd_v = '0;
      ack_v = '0;
      rst_v = '1;
      repeat (3) tick();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("u%0d.reset_state", i), 32'(state_v[i]), 32'd0);
         check($sformatf("u%0d.reset_cnt", i), 32'(cnt_v[i]), 32'd0);
         check($sformatf("u%0d.reset_busy", i), 32'(busy_v[i]), 32'd0);
      end
      rst_v = '0;
      repeat (6) tick();

      // good frame, 4 clocks per bit; held until ack
      send_frame(0, 8'hA5, 1'b0);
      idle(0, 12);
      ack_pulse(0);
      idle(0, 4);

      // back-to-back frames at 1 clock per bit, ack after the first
      r = cyc + 1;
      fork
         begin
            send_frame(1, 8'h3C, 1'b0);
            send_frame(1, 8'hFF, 1'b0);
         end
         begin
            wait_until(r + lat_of(1));
            ack_v[1] = 1'b1;
            tick();
            ack_v[1] = 1'b0;
         end
      join
      idle(1, 6);
      ack_pulse(1);

      // one-cycle glitch at 8 clocks per bit: false start
      tick();
      rxd_v[2] = 1'b1;
      r = cyc;
      tick();
      rxd_v[2] = 1'b0;
      wait_until(r + 6);
      check("glitch_busy_start", 32'(busy_v[2]), 32'd1);
      tick();
      check("glitch_busy_idle", 32'(busy_v[2]), 32'd0);
      check("glitch_state_idle", 32'(state_v[2]), 32'd0);

      // bad stop bit keeps the previous byte, then a good frame follows
      send_frame(2, 8'h77, 1'b0);
      idle(2, 10);
      ack_pulse(2);
      send_frame(2, 8'h12, 1'b1);
      idle(2, 12);
      send_frame(2, 8'h34, 1'b0);
      idle(2, 10);
      ack_pulse(2);

      // overrun, then completion coinciding with ack
      send_frame(0, 8'h11, 1'b0);
      send_frame(0, 8'h22, 1'b0);
      idle(0, 8);
      r = cyc + 1;
      fork
         send_frame(0, 8'h33, 1'b0);
         begin
            wait_until(r + lat_of(0) - 1);
            ack_v[0] = 1'b1;
            tick();
            ack_v[0] = 1'b0;
         end
      join
      idle(0, 8);
      ack_pulse(0);
      idle(0, 4);

      // reset in the middle of a frame, line left high across release
      tick();
      rxd_v[0] = 1'b1;
      r = cyc;
      wait_until(r + 21);
      check("midframe_state", 32'(state_v[0]), 32'd2);
      check("midframe_cnt", 32'(cnt_v[0]), 32'd4);
      rst_v[0] = 1'b1;
      tick();
      check("rst_state", 32'(state_v[0]), 32'd0);
      check("rst_cnt", 32'(cnt_v[0]), 32'd0);
      tick();
      rst_v[0] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         repeat (5) tick();
         check("high_after_rst_busy", 32'(busy_v[0]), 32'd0);
      end
      idle(0, 4);
      send_frame(0, 8'h5A, 1'b0);
      idle(0, 8);
      ack_pulse(0);

      // randomized frames with random ack activity
      for (int s = 0; s < 3; s++) begin
         for (int f = 0; f < 10; f++) begin
            logic [7:0] d;
            bit         bad;
            d   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 5) == 0);
            rnd_done = 1'b0;
            fork
               begin
                  send_frame(s, d, bad);
                  rnd_done = 1'b1;
               end
               begin
                  while (!rnd_done) begin
                     ack_v[s] = ($urandom_range(0, 3) == 0);
                     tick();
                  end
                  ack_v[s] = 1'b0;
               end
            join
            idle(s, $urandom_range(bad ? 1 : 0, 2 * cpb_of(s)));
         end
         idle(s, 2 * lat_of(s));
      end

      guard = 0;
      while (exp_q.size() != 0 && guard < 2000) begin
         tick();
         guard++;
      end
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
